// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the writeback request record used by
// the register-file write-port arbiter.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/mips_wb_arbiter_if.sv
// Writeback bus: two valid/ready requesters, the register-file write port
// and the decode-stage forwarding view of the in-flight write.
interface mips_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteAddress;
  logic [DATA_W-1:0] DataIn;

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data;

  logic              alu_starved;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  RegWrite, WriteAddress, DataIn,
    output rd_addr1, rd_addr2,
    input  fwd_hit1, fwd_hit2, fwd_data,
    input  alu_starved
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output RegWrite, WriteAddress, DataIn,
    input  rd_addr1, rd_addr2,
    output fwd_hit1, fwd_hit2, fwd_data,
    output alu_starved
  );

endinterface

// File: rtl/mips_wb_starve_cnt.sv
// Counts consecutive cycles the ALU requester has been refused and flags
// when it must be forced to win arbitration.
module mips_wb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_valid,
  input  logic       alu_ready,
  output logic       force_alu,
  output logic       starved
);

  logic [3:0] wait_cnt;

  // Only an uninterrupted run of refused requests counts; saturate at 15.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 4'd0;
    end else if (!alu_valid || alu_ready) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign force_alu = (wait_cnt >= 4'(MAX_WAIT));
  assign starved   = force_alu && alu_valid;

endmodule

// File: rtl/mips_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load
// writeback, registers the winner and exposes it for decode forwarding.
module mips_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int ADDR_W   = mips_pkg::REG_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  mips_wb_arbiter_if.slave    bus
);

  import mips_pkg::*;

  wb_req_t alu_req;
  wb_req_t mem_req;
  wb_req_t win_req;

  logic force_alu;
  logic grant_alu;
  logic grant_mem;
  logic xfer;

  mips_wb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (bus.alu_valid),
    .alu_ready (bus.alu_ready),
    .force_alu (force_alu),
    .starved   (bus.alu_starved)
  );

  assign alu_req.addr = bus.alu_addr;
  assign alu_req.data = bus.alu_data;
  assign mem_req.addr = bus.mem_addr;
  assign mem_req.data = bus.mem_data;

  // Loads normally win contention; a starved ALU request takes the port.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (rst) begin
      grant_alu = bus.alu_valid && (!bus.mem_valid || force_alu);
      grant_mem = bus.mem_valid && !grant_alu;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign xfer          = grant_alu || grant_mem;
  assign win_req       = grant_alu ? alu_req : mem_req;

  // Writes to $0 are accepted but never raise the write enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.RegWrite     <= 1'b0;
      bus.WriteAddress <= '0;
      bus.DataIn       <= '0;
    end else if (xfer) begin
      bus.RegWrite     <= (win_req.addr != REG_ZERO);
      bus.WriteAddress <= win_req.addr;
      bus.DataIn       <= win_req.data;
    end else begin
      bus.RegWrite     <= 1'b0;
    end
  end

  assign bus.fwd_hit1 = bus.RegWrite && (bus.WriteAddress == bus.rd_addr1) &&
                        (bus.rd_addr1 != REG_ZERO);
  assign bus.fwd_hit2 = bus.RegWrite && (bus.WriteAddress == bus.rd_addr2) &&
                        (bus.rd_addr2 != REG_ZERO);
  assign bus.fwd_data = bus.DataIn;

endmodule

// File: doc/mips_wb_arbiter.md
Name: mips_wb_arbiter

Overview:
Arbitrates the register file's single write port between two writeback requesters: ALU/link results and memory load results. Loads return from a variable-latency memory interface. Accepts one write per cycle over valid/ready handshakes and registers it onto the register-file write port (RegWrite/WriteAddress/DataIn). Exposes a forwarding view of the in-flight write so the decode stage can bypass the one-cycle write latency.

Parameters:
MAX_WAIT, 4, consecutive cycles the ALU requester may lose arbitration before it is forced to win (1..15)
DATA_W, 32, write data width
ADDR_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
alu_valid  in  1  ALU writeback request
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle (combinational)
mem_valid  in  1  load writeback request
mem_addr  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load request accepted this cycle (combinational)
RegWrite  out  1  register-file write enable (registered)
WriteAddress  out  ADDR_W  register-file write address (registered)
DataIn  out  DATA_W  register-file write data (registered)
rd_addr1  in  ADDR_W  decode read address 1
rd_addr2  in  ADDR_W  decode read address 2
fwd_hit1  out  1  pending write matches rd_addr1 (combinational)
fwd_hit2  out  1  pending write matches rd_addr2 (combinational)
fwd_data  out  DATA_W  equals DataIn; valid when fwd_hit1 or fwd_hit2 is high
alu_starved  out  1  ALU forced-priority mode active

Behaviour:
- Reset (rst==0 at posedge): RegWrite=0, WriteAddress=0, DataIn=0, wait counter=0, alu_starved=0. Ready outputs are 0 while rst==0. Reset mid-transfer discards the pending write; RegWrite is low the cycle after.
- Arbitration (combinational, per cycle):
  - If only one requester is valid, it wins.
  - If both are valid: mem wins unless wait_cnt >= MAX_WAIT, in which case alu wins.
- Handshake: X_ready = grant_X. A transfer occurs when X_valid && X_ready. Requesters hold valid/addr/data stable until ready.
- Output register: on a transfer, at the next edge WriteAddress<=addr and DataIn<=data. RegWrite<=1 only if addr!=0; a $0 write is accepted and silently dropped. With no transfer, RegWrite<=0 and WriteAddress/DataIn hold their values.
- Latency: 1 cycle from handshake to RegWrite. The register file commits on the following edge. Throughput is 1 write per cycle.
- Starvation counter wait_cnt (4 bits):
  - Increments, saturating at 15, when alu_valid && !alu_ready.
  - Clears on an alu transfer or when alu_valid==0.
  - alu_starved = (wait_cnt >= MAX_WAIT) && alu_valid.
- Forwarding: fwd_hitN = RegWrite && (WriteAddress==rd_addrN) && (rd_addrN!=0).
- Same destination from both requesters in one cycle: only the winner is written. The loser writes in a later cycle, so the last write wins in arbitration order.

Decomposition:
- Shared package mips_pkg holds REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0, and a typedef wb_req_t {addr, data}.
- One natural sub-module: mips_wb_starve_cnt (saturating wait counter plus threshold compare). The arbiter, output register and forwarding compare stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both requesters valid -> RegWrite=0, both ready=0, WriteAddress=0, DataIn=0; release -> mem granted first.
- Single ALU write: alu_valid=1, addr=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle RegWrite=1, WriteAddress=5, DataIn=0xDEADBEEF; rd_addr1=5 -> fwd_hit1=1, fwd_data=0xDEADBEEF.
- $0 drop: mem_valid=1, addr=0, data=0x1234 -> mem_ready=1; next cycle RegWrite=0, fwd_hit1=0 with rd_addr1=0.
- Contention: both valid continuously, MAX_WAIT=4, mem addr=7, ALU addr=9 -> mem wins cycles 0-3; alu_starved=1 in cycle 4 and ALU wins; WriteAddress=9 in cycle 5; counter back to 0.
- Back-to-back: mem writes 3,4,6 on consecutive cycles -> RegWrite high 3 consecutive cycles with matching addresses/data, then low.
- Reset mid-stream: assert rst=0 the cycle after a transfer -> RegWrite=0 next cycle, wait_cnt=0.
